// File: rtl/reorder_buffer.sv
// reorder_buffer: 32-entry, dual-issue, dual-retire reorder buffer.
//
// Entries are allocated in program order at the tail (up to two per cycle),
// marked done by any of four writeback ports, and retired in order from the
// head (up to two per cycle) once done.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   flush                     (ROB_FLUSH_EN only) discard every entry
//   stall                     front-end stall, blocks allocation
//   alloc1/2, RegWrite1/2,    issue slots: valid, writes-register, dest reg
//   DestReg1/2
//   tag1/2                    tags handed to issue slots 1 and 2
//   rob_full                  fewer than two free entries
//   alu1/alu2/ld1/ld2 _wr,    writeback ports: valid, tag, value
//   _res_tag, _data
//   commit1/2, commit1/2_addr retire strobes with dest reg, tag and value
//   commit1/2_tag/_data
//
// Build option: define ROB_FLUSH_EN to add the flush input.
module reorder_buffer #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
`ifdef ROB_FLUSH_EN
   input  logic              flush,
`endif
   input  logic              stall,
   input  logic              alloc1,
   input  logic              alloc2,
   input  logic              RegWrite1,
   input  logic              RegWrite2,
   input  logic [4:0]        DestReg1,
   input  logic [4:0]        DestReg2,
   output logic [4:0]        tag1,
   output logic [4:0]        tag2,
   output logic              rob_full,
   input  logic              alu1_wr,
   input  logic              alu2_wr,
   input  logic              ld1_wr,
   input  logic              ld2_wr,
   input  logic [4:0]        alu1_res_tag,
   input  logic [4:0]        alu2_res_tag,
   input  logic [4:0]        ld1_res_tag,
   input  logic [4:0]        ld2_res_tag,
   input  logic [DATA_W-1:0] alu1_data,
   input  logic [DATA_W-1:0] alu2_data,
   input  logic [DATA_W-1:0] ld1_data,
   input  logic [DATA_W-1:0] ld2_data,
   output logic              commit1,
   output logic              commit2,
   output logic [4:0]        commit1_addr,
   output logic [4:0]        commit2_addr,
   output logic [4:0]        commit1_tag,
   output logic [4:0]        commit2_tag,
   output logic [DATA_W-1:0] commit1_data,
   output logic [DATA_W-1:0] commit2_data
);

   logic [31:0]       valid_q, valid_d;
   logic [31:0]       done_q, done_d;
   logic [4:0]        dest_q [32];
   logic [4:0]        dest_d [32];
   logic [DATA_W-1:0] data_q [32];
   logic [DATA_W-1:0] data_d [32];
   logic [4:0]        head_q, head_d;
   logic [4:0]        tail_q, tail_d;
   logic [5:0]        count_q, count_d;

   logic              flush_act;
   logic              alloc_en;
   logic [1:0]        n_alloc;
   logic [1:0]        n_commit;
   logic [4:0]        head_p1;

`ifdef ROB_FLUSH_EN
   assign flush_act = flush;
`else
   assign flush_act = 1'b0;
`endif

   // Issue and retire decisions, all from current state.
   always_comb begin
      tag1     = tail_q;
      tag2     = alloc1 ? tail_q + 5'd1 : tail_q;
      rob_full = count_q > 6'd30;
      alloc_en = !stall && !rob_full && !flush_act;
      n_alloc  = alloc_en ? ({1'b0, alloc1} + {1'b0, alloc2}) : 2'd0;

      head_p1  = head_q + 5'd1;
      commit1  = !flush_act && valid_q[head_q] && done_q[head_q];
      commit2  = commit1 && valid_q[head_p1] && done_q[head_p1];
      n_commit = {1'b0, commit1} + {1'b0, commit2};

      commit1_addr = dest_q[head_q];
      commit2_addr = dest_q[head_p1];
      commit1_tag  = head_q;
      commit2_tag  = head_p1;
      commit1_data = data_q[head_q];
      commit2_data = data_q[head_p1];
   end

   always_comb begin
      valid_d = valid_q;
      done_d  = done_q;
      dest_d  = dest_q;
      data_d  = data_q;

      // Lowest priority first so higher-priority ports overwrite duplicates.
      if (!flush_act) begin
         if (ld2_wr && valid_q[ld2_res_tag]) begin
            done_d[ld2_res_tag] = 1'b1;
            data_d[ld2_res_tag] = ld2_data;
         end
         if (ld1_wr && valid_q[ld1_res_tag]) begin
            done_d[ld1_res_tag] = 1'b1;
            data_d[ld1_res_tag] = ld1_data;
         end
         if (alu2_wr && valid_q[alu2_res_tag]) begin
            done_d[alu2_res_tag] = 1'b1;
            data_d[alu2_res_tag] = alu2_data;
         end
         if (alu1_wr && valid_q[alu1_res_tag]) begin
            done_d[alu1_res_tag] = 1'b1;
            data_d[alu1_res_tag] = alu1_data;
         end
      end

      if (commit1) begin
         valid_d[head_q] = 1'b0;
         done_d[head_q]  = 1'b0;
      end
      if (commit2) begin
         valid_d[head_p1] = 1'b0;
         done_d[head_p1]  = 1'b0;
      end

      // Allocated entries are free (not valid), so they never collide with
      // the retiring ones above.
      if (alloc_en && alloc1) begin
         valid_d[tag1] = 1'b1;
         done_d[tag1]  = 1'b0;
         dest_d[tag1]  = RegWrite1 ? DestReg1 : 5'd0;
      end
      if (alloc_en && alloc2) begin
         valid_d[tag2] = 1'b1;
         done_d[tag2]  = 1'b0;
         dest_d[tag2]  = RegWrite2 ? DestReg2 : 5'd0;
      end

      head_d  = head_q + {3'd0, n_commit};
      tail_d  = tail_q + {3'd0, n_alloc};
      count_d = count_q + {4'd0, n_alloc} - {4'd0, n_commit};

      if (flush_act) begin
         valid_d = '0;
         done_d  = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         done_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         done_q  <= done_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload needs no reset: it is only observed behind valid/done.
   always_ff @(posedge clk) begin
      dest_q <= dest_d;
      data_q <= data_d;
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboarded bench for reorder_buffer: the driver pushes each expected
// retirement when it allocates the entry; a monitor pops on every commit.
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        rst;
`ifdef ROB_FLUSH_EN
   logic        flush;
`endif
   logic        stall, alloc1, alloc2, RegWrite1, RegWrite2;
   logic [4:0]  DestReg1, DestReg2, tag1, tag2;
   logic        rob_full;
   logic        alu1_wr, alu2_wr, ld1_wr, ld2_wr;
   logic [4:0]  alu1_res_tag, alu2_res_tag, ld1_res_tag, ld2_res_tag;
   logic [31:0] alu1_data, alu2_data, ld1_data, ld2_data;
   logic        commit1, commit2;
   logic [4:0]  commit1_addr, commit2_addr, commit1_tag, commit2_tag;
   logic [31:0] commit1_data, commit2_data;

   typedef struct packed {
      logic [4:0]  addr;
      logic [4:0]  tag;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   reorder_buffer #(.DATA_W(32)) dut (
      .clk(clk),
      .rst(rst),
`ifdef ROB_FLUSH_EN
      .flush(flush),
`endif
      .stall(stall),
      .alloc1(alloc1),
      .alloc2(alloc2),
      .RegWrite1(RegWrite1),
      .RegWrite2(RegWrite2),
      .DestReg1(DestReg1),
      .DestReg2(DestReg2),
      .tag1(tag1),
      .tag2(tag2),
      .rob_full(rob_full),
      .alu1_wr(alu1_wr),
      .alu2_wr(alu2_wr),
      .ld1_wr(ld1_wr),
      .ld2_wr(ld2_wr),
      .alu1_res_tag(alu1_res_tag),
      .alu2_res_tag(alu2_res_tag),
      .ld1_res_tag(ld1_res_tag),
      .ld2_res_tag(ld2_res_tag),
      .alu1_data(alu1_data),
      .alu2_data(alu2_data),
      .ld1_data(ld1_data),
      .ld2_data(ld2_data),
      .commit1(commit1),
      .commit2(commit2),
      .commit1_addr(commit1_addr),
      .commit2_addr(commit2_addr),
      .commit1_tag(commit1_tag),
      .commit2_tag(commit2_tag),
      .commit1_data(commit1_data),
      .commit2_data(commit2_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [4:0] addr, input logic [4:0] tag,
                               input logic [31:0] data);
      exp_t e;
      e.addr = addr;
      e.tag  = tag;
      e.data = data;
      return e;
   endfunction

   function automatic logic [31:0] dval(input int k);
      return 32'h1000 + 32'(k);
   endfunction

   task automatic idle();
`ifdef ROB_FLUSH_EN
      flush = 1'b0;
`endif
      stall = 1'b0; alloc1 = 1'b0; alloc2 = 1'b0;
      RegWrite1 = 1'b0; RegWrite2 = 1'b0; DestReg1 = '0; DestReg2 = '0;
      alu1_wr = 1'b0; alu2_wr = 1'b0; ld1_wr = 1'b0; ld2_wr = 1'b0;
      alu1_res_tag = '0; alu2_res_tag = '0; ld1_res_tag = '0; ld2_res_tag = '0;
      alu1_data = '0; alu2_data = '0; ld1_data = '0; ld2_data = '0;
   endtask

   // Advance one cycle; returns just after the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
      chk(name, 64'(sb.size()), 64'd0);
   endtask

   task automatic pop_cmp(input string name, input logic [4:0] addr, input logic [4:0] tag,
                          input logic [31:0] data);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s unexpected: got addr=%0d tag=%0d data=%0h, required none",
                  name, addr, tag, data);
      end else begin
         e = sb.pop_front();
         if (addr !== e.addr || tag !== e.tag || data !== e.data) begin
            errors++;
            $display("FAIL %s: got addr=%0d tag=%0d data=%0h, required addr=%0d tag=%0d data=%0h",
                     name, addr, tag, data, e.addr, e.tag, e.data);
         end
      end
   endtask

   // Monitor: compare every retirement against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst === 1'b1) begin
            if (commit1 === 1'b1) pop_cmp("commit1", commit1_addr, commit1_tag, commit1_data);
            if (commit2 === 1'b1) pop_cmp("commit2", commit2_addr, commit2_tag, commit2_data);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int t;
      idle();
      rst = 1'b0;
      alloc1 = 1'b1;
      tick();
      tick();
      #1;
      chk("reset_rob_full", 64'(rob_full), 64'd0);
      chk("reset_commit1", 64'(commit1), 64'd0);
      chk("reset_commit2", 64'(commit2), 64'd0);
      chk("reset_tag1", 64'(tag1), 64'd0);
      chk("reset_tag2", 64'(tag2), 64'd1);
      idle();
      rst = 1'b1;
      tick();

      // Dual allocate, writeback out of order, dual retire.
      alloc1 = 1'b1; alloc2 = 1'b1; RegWrite1 = 1'b1; RegWrite2 = 1'b1;
      DestReg1 = 5'd3; DestReg2 = 5'd4;
      #1;
      chk("alloc_tag1", 64'(tag1), 64'd0);
      chk("alloc_tag2", 64'(tag2), 64'd1);
      sb.push_back(mk(5'd3, 5'd0, 32'h10));
      sb.push_back(mk(5'd4, 5'd1, 32'h11));
      tick();
      idle();
      chk("alloc_tail", 64'(dut.tail_q), 64'd2);
      chk("alloc_count", 64'(dut.count_q), 64'd2);
      alu1_wr = 1'b1; alu1_res_tag = 5'd1; alu1_data = 32'h11;
      tick();
      idle();
      #1;
      chk("no_commit_out_of_order", 64'(commit1), 64'd0);
      alu2_wr = 1'b1; alu2_res_tag = 5'd0; alu2_data = 32'h10;
      tick();
      idle();
      #1;
      chk("dual_commit1", 64'(commit1), 64'd1);
      chk("dual_commit2", 64'(commit2), 64'd1);
      chk("dual_addr1", 64'(commit1_addr), 64'd3);
      chk("dual_addr2", 64'(commit2_addr), 64'd4);
      tick();
      chk("after_commit_count", 64'(dut.count_q), 64'd0);

      // Tags 2..5; tag 4 does not write a register; duplicate writebacks.
      alloc1 = 1'b1; alloc2 = 1'b1; RegWrite1 = 1'b1; RegWrite2 = 1'b1;
      DestReg1 = 5'd12; DestReg2 = 5'd13;
      sb.push_back(mk(5'd12, 5'd2, 32'h22));
      sb.push_back(mk(5'd13, 5'd3, 32'h33));
      tick();
      idle();
      alloc1 = 1'b1; alloc2 = 1'b1; RegWrite1 = 1'b0; RegWrite2 = 1'b1;
      DestReg1 = 5'd14; DestReg2 = 5'd15;
      #1;
      chk("tag1_at_4", 64'(tag1), 64'd4);
      sb.push_back(mk(5'd0, 5'd4, 32'h44));
      sb.push_back(mk(5'd15, 5'd5, 32'hAAAA));
      tick();
      idle();
      alu1_wr = 1'b1; alu1_res_tag = 5'd5; alu1_data = 32'hAAAA;
      ld2_wr  = 1'b1; ld2_res_tag  = 5'd5; ld2_data  = 32'h5555;
      alu2_wr = 1'b1; alu2_res_tag = 5'd2; alu2_data = 32'h22;
      ld1_wr  = 1'b1; ld1_res_tag  = 5'd3; ld1_data  = 32'h33;
      tick();
      idle();
      alu1_wr = 1'b1; alu1_res_tag = 5'd4;  alu1_data = 32'h44;
      alu2_wr = 1'b1; alu2_res_tag = 5'd20; alu2_data = 32'hBAD;
      tick();
      idle();
      chk("invalid_wb_done", 64'(dut.done_q[20]), 64'd0);
      chk("invalid_wb_valid", 64'(dut.valid_q[20]), 64'd0);
      wait_drain("drain_prio");
      chk("prio_count", 64'(dut.count_q), 64'd0);
      chk("prio_tail", 64'(dut.tail_q), 64'd6);

      // Fill to 31 entries from tail 6, crossing the 31 -> 0 wrap in one cycle.
      alloc1 = 1'b1; RegWrite1 = 1'b1; DestReg1 = 5'd6;
      sb.push_back(mk(5'd6, 5'd6, dval(6)));
      tick();
      idle();
      for (int i = 0; i < 15; i++) begin
         t = (7 + 2 * i) % 32;
         alloc1 = 1'b1; alloc2 = 1'b1; RegWrite1 = 1'b1; RegWrite2 = 1'b1;
         DestReg1 = 5'(t); DestReg2 = 5'((t + 1) % 32);
         #1;
         chk("fill_tag1", 64'(tag1), 64'(t));
         chk("fill_tag2", 64'(tag2), 64'((t + 1) % 32));
         sb.push_back(mk(5'(t), 5'(t), dval(t)));
         sb.push_back(mk(5'((t + 1) % 32), 5'((t + 1) % 32), dval((t + 1) % 32)));
         tick();
         idle();
      end
      chk("full_count", 64'(dut.count_q), 64'd31);
      alloc1 = 1'b1; alloc2 = 1'b1;
      #1;
      chk("full_flag", 64'(rob_full), 64'd1);
      tick();
      idle();
      chk("full_ignored_tail", 64'(dut.tail_q), 64'd5);
      chk("full_ignored_count", 64'(dut.count_q), 64'd31);
      alu1_wr = 1'b1; alu1_res_tag = 5'd6; alu1_data = dval(6);
      tick();
      idle();
      alloc1 = 1'b1; RegWrite1 = 1'b1; DestReg1 = 5'd9;
      #1;
      chk("full_during_commit", 64'(rob_full), 64'd1);
      chk("full_commit1", 64'(commit1), 64'd1);
      tick();
      idle();
      chk("one_free_count", 64'(dut.count_q), 64'd30);
      alloc1 = 1'b1; RegWrite1 = 1'b1; DestReg1 = 5'd5;
      #1;
      chk("one_free_flag", 64'(rob_full), 64'd0);
      chk("one_free_tag1", 64'(tag1), 64'd5);
      sb.push_back(mk(5'd5, 5'd5, dval(5)));
      tick();
      idle();
      chk("refill_count", 64'(dut.count_q), 64'd31);
      chk("refill_tail", 64'(dut.tail_q), 64'd6);

      // Drain tags 7..31,0..5 two per cycle; order checked by the monitor.
      for (int j = 0; j < 31; j += 2) begin
         alu1_wr = 1'b1; alu1_res_tag = 5'((7 + j) % 32); alu1_data = dval((7 + j) % 32);
         if (j + 1 < 31) begin
            ld1_wr = 1'b1; ld1_res_tag = 5'((8 + j) % 32); ld1_data = dval((8 + j) % 32);
         end
         tick();
         idle();
      end
      wait_drain("drain_wrap");
      chk("wrap_count", 64'(dut.count_q), 64'd0);

`ifdef ROB_FLUSH_EN
      for (int i = 0; i < 4; i++) begin
         alloc1 = 1'b1; alloc2 = (i < 3);
         tick();
         idle();
      end
      chk("preflush_count", 64'(dut.count_q), 64'd7);
      flush = 1'b1; alloc1 = 1'b1; alloc2 = 1'b1;
      alu1_wr = 1'b1; alu1_res_tag = 5'd6; alu1_data = 32'h66;
      #1;
      chk("flush_commit1", 64'(commit1), 64'd0);
      tick();
      idle();
      alloc1 = 1'b1; alloc2 = 1'b1;
      #1;
      chk("postflush_count", 64'(dut.count_q), 64'd0);
      chk("postflush_commit1", 64'(commit1), 64'd0);
      chk("postflush_tag1", 64'(tag1), 64'd0);
      chk("postflush_tag2", 64'(tag2), 64'd1);
      tick();
      idle();
      chk("postflush_tail", 64'(dut.tail_q), 64'd2);
`endif

      // Reset asserted in the middle of an allocation.
      alloc1 = 1'b1; alloc2 = 1'b1;
      rst = 1'b0;
      tick();
      #1;
      chk("midreset_count", 64'(dut.count_q), 64'd0);
      chk("midreset_tail", 64'(dut.tail_q), 64'd0);
      chk("midreset_commit1", 64'(commit1), 64'd0);
      idle();
      rst = 1'b1;
      tick();
      chk("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the result data width.
REQ-002 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port stall, input, 1: external front-end stall; blocks allocation.
REQ-005 SHALL have ports alloc1 and alloc2, input, 1 each: issue slot valid.
REQ-006 SHALL have ports RegWrite1 and RegWrite2, input, 1 each: slot writes a register.
REQ-007 SHALL have ports DestReg1 and DestReg2, input, 5 each: slot destination register.
REQ-008 SHALL have ports tag1 and tag2, output, 5 each: ROB tags assigned to slots 1 and 2.
REQ-009 SHALL have port rob_full, output, 1: fewer than 2 free entries.
REQ-010 SHALL have ports alu1_wr, alu2_wr, ld1_wr and ld2_wr, input, 1 each: writeback valid.
REQ-011 SHALL have ports alu1_res_tag, alu2_res_tag, ld1_res_tag and ld2_res_tag, input, 5 each: writeback tag.
REQ-012 SHALL have ports alu1_data, alu2_data, ld1_data and ld2_data, input, DATA_W each: writeback value.
REQ-013 SHALL have ports commit1 and commit2, output, 1 each: entry retiring this cycle.
REQ-014 SHALL have ports commit1_addr and commit2_addr, output, 5 each: retiring destination register.
REQ-015 SHALL have ports commit1_tag and commit2_tag, output, 5 each: retiring entry tag.
REQ-016 SHALL have ports commit1_data and commit2_data, output, DATA_W each: retiring value.

Function
REQ-017 SHALL hold 32 entries (valid, done, dest, data), a circular 5-bit head and tail, and a 6-bit count.
REQ-018 SHALL drive tag1 = tail, and tag2 = tail+1 when alloc1=1 or tail when alloc1=0; both combinational, mod 32.
REQ-019 SHALL drive rob_full = (count > 30), combinational, using current count; a same-cycle commit does not clear it.
REQ-020 SHALL allocate only when stall=0 and rob_full=0: set valid=1, done=0, dest=DestReg (0 if RegWrite=0); advance tail by alloc1+alloc2.
REQ-021 SHALL set done=1 and store data for a writeback whose tag names a valid entry; writebacks to invalid entries SHALL be ignored.
REQ-022 SHALL resolve duplicate writeback tags in one cycle by priority alu1 > alu2 > ld1 > ld2.
REQ-023 SHALL make writeback visible to commit one cycle later; there is no same-cycle bypass.
REQ-024 SHALL assert commit1 combinationally when the head entry is valid and done; commit2 only when commit1=1 and head+1 is valid and done.
REQ-025 SHALL, on the commit edge, clear the valid bit of each retired entry and advance head by commit1+commit2.
REQ-026 SHALL update count = count + allocated - committed; simultaneous allocation and commit are both honoured.
REQ-027 SHALL wrap head and tail from 31 to 0 with no gap entry.

Reset
REQ-028 SHALL, while rst=0, clear head, tail, count and every valid/done bit, giving rob_full=0, commit1=commit2=0, tag1=0 and tag2=1.
REQ-029 SHALL abandon an allocation or commit in progress when rst asserts mid-operation; no partial state survives.

Configuration
REQ-030 SHALL, with ROB_FLUSH_EN defined, add a 1-bit input flush; flush=1 clears head, tail, count and valid at the next edge, ignores that cycle's allocations and writebacks, and forces commit1=commit2=0.
REQ-031 SHALL, without ROB_FLUSH_EN, have no flush port and no flush behaviour.

Verification
REQ-032 SHALL check: after reset, alloc1=alloc2=1 with DestReg 3/4 -> tag1=0, tag2=1; next cycle tail=2, count=2.
REQ-033 SHALL check: writebacks to tags 1 then 0 -> commit1 and commit2 both asserted in the cycle after tag 0 is written, with addrs 3 and 4.
REQ-034 SHALL check: fill to count=31 -> rob_full=1 and allocation ignored; one commit -> count=30, rob_full=0, next allocation accepted.
REQ-035 SHALL check: alu1 and ld2 both write tag 5 with 0xAAAA and 0x5555 -> committed data is 0xAAAA.
REQ-036 SHALL check: tail=31 with alloc1=alloc2=1 -> tags 31 and 0; the commit stream retires 31 then 0 in order.
REQ-037 SHALL check: with ROB_FLUSH_EN, flush with count=7 -> next cycle count=0 and commit1=0, and a later allocation gets tag1=0.
